// File: rtl/stall_flush_controller.sv
// Purpose: central stall/flush control for the 5-stage core, with divide occupancy FSM and stall counter.
// Latency: enables/flushes are combinational (zero-cycle); FSM, DCNT and stall counter update on core_clk.
// Backpressure: DMEM_BUSY freezes PC..EX/MEM, a running divide freezes PC..ID/EX, then branch > load-use > fetch.
module stall_flush_controller #(
  parameter int DIV_CYCLES = 4
) (
  input  logic        core_clk,
  input  logic        rst,
  input  logic        lu_hazard,
  input  logic        branch_taken_ex,
  input  logic        div_valid_ex,
  input  logic        imem_busy,
  input  logic        dmem_busy,
  output logic        pc_write_en,
  output logic        if_id_write_en,
  output logic        id_ex_write_en,
  output logic        ex_mem_write_en,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        ex_mem_flush,
  output logic        mem_wb_flush,
  output logic        div_busy,
  output logic [31:0] stall_cycles
);

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    DIV_WAIT = 1'b1
  } state_t;

  // The entry cycle in RUN is already one stall cycle, so the wait counter covers the rest minus the release cycle.
  localparam logic [3:0] DCNT_LOAD = 4'(DIV_CYCLES - 2);

  state_t     state;
  logic [3:0] dcnt;
  logic       div_stall;

  // Divide holds the front end on its entry cycle and while the wait counter is still running.
  always_comb begin
    div_stall = 1'b0;
    if (state == RUN) begin
      div_stall = div_valid_ex;
    end else begin
      div_stall = (dcnt != 4'd0);
    end
  end

  // Divide occupancy FSM; release is held off while MEM is busy so EX is not lost, without restarting the count.
  always_ff @(posedge core_clk or posedge rst) begin
    if (rst) begin
      state    <= RUN;
      dcnt     <= 4'd0;
      div_busy <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (div_valid_ex) begin
            state    <= DIV_WAIT;
            dcnt     <= DCNT_LOAD;
            div_busy <= 1'b1;
          end
        end
        DIV_WAIT: begin
          if (dcnt != 4'd0) begin
            dcnt <= dcnt - 4'd1;
          end else if (!dmem_busy) begin
            state    <= RUN;
            div_busy <= 1'b0;
          end
        end
        default: begin
          state    <= RUN;
          dcnt     <= 4'd0;
          div_busy <= 1'b0;
        end
      endcase
    end
  end

  // Priority resolution of the stall/flush conditions; reset forces every register to bubble.
  always_comb begin
    pc_write_en     = 1'b1;
    if_id_write_en  = 1'b1;
    id_ex_write_en  = 1'b1;
    ex_mem_write_en = 1'b1;
    if_id_flush     = 1'b0;
    id_ex_flush     = 1'b0;
    ex_mem_flush    = 1'b0;
    mem_wb_flush    = 1'b0;
    if (rst) begin
      pc_write_en     = 1'b0;
      if_id_write_en  = 1'b0;
      id_ex_write_en  = 1'b0;
      ex_mem_write_en = 1'b0;
      if_id_flush     = 1'b1;
      id_ex_flush     = 1'b1;
      ex_mem_flush    = 1'b1;
      mem_wb_flush    = 1'b1;
    end else if (dmem_busy) begin
      pc_write_en     = 1'b0;
      if_id_write_en  = 1'b0;
      id_ex_write_en  = 1'b0;
      ex_mem_write_en = 1'b0;
      mem_wb_flush    = 1'b1;
    end else if (div_stall) begin
      pc_write_en     = 1'b0;
      if_id_write_en  = 1'b0;
      id_ex_write_en  = 1'b0;
      ex_mem_flush    = 1'b1;
    end else if (branch_taken_ex) begin
      if_id_flush     = 1'b1;
      id_ex_flush     = 1'b1;
    end else if (lu_hazard) begin
      pc_write_en     = 1'b0;
      if_id_write_en  = 1'b0;
      id_ex_flush     = 1'b1;
    end else if (imem_busy) begin
      pc_write_en     = 1'b0;
      if_id_flush     = 1'b1;
    end
  end

  // Performance counter of cycles in which the PC did not advance; wraps naturally.
  always_ff @(posedge core_clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= 32'd0;
    end else if (!pc_write_en) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end

endmodule

// File: tb/tb_stall_flush_controller.sv
// Purpose: directed bench for stall_flush_controller with a cycle-level reference model.
// Latency: inputs driven 1ns after core_clk rise, outputs checked on the falling edge.
// Backpressure: not applicable; each step is one clock cycle.
module tb_stall_flush_controller;

  localparam int DIV_CYCLES = 4;

  logic        core_clk = 1'b0;
  logic        rst = 1'b1;
  logic        lu_hazard = 1'b1;
  logic        branch_taken_ex = 1'b1;
  logic        div_valid_ex = 1'b1;
  logic        imem_busy = 1'b1;
  logic        dmem_busy = 1'b1;
  logic        pc_write_en, if_id_write_en, id_ex_write_en, ex_mem_write_en;
  logic        if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
  logic        div_busy;
  logic [31:0] stall_cycles;

  stall_flush_controller #(.DIV_CYCLES(DIV_CYCLES)) dut (
    .core_clk        (core_clk),
    .rst             (rst),
    .lu_hazard       (lu_hazard),
    .branch_taken_ex (branch_taken_ex),
    .div_valid_ex    (div_valid_ex),
    .imem_busy       (imem_busy),
    .dmem_busy       (dmem_busy),
    .pc_write_en     (pc_write_en),
    .if_id_write_en  (if_id_write_en),
    .id_ex_write_en  (id_ex_write_en),
    .ex_mem_write_en (ex_mem_write_en),
    .if_id_flush     (if_id_flush),
    .id_ex_flush     (id_ex_flush),
    .ex_mem_flush    (ex_mem_flush),
    .mem_wb_flush    (mem_wb_flush),
    .div_busy        (div_busy),
    .stall_cycles    (stall_cycles)
  );

  always #5 core_clk = ~core_clk;

  // Stimulus-owned literal expectations, consumed by the compare process.
  logic        started = 1'b0;
  logic        lit_vld = 1'b0;
  logic [8:0]  lit_exp = 9'd0;
  logic        lit_cnt_vld = 1'b0;
  logic [31:0] lit_cnt = 32'd0;
  int          preload_seq = 0;

  // Compare-process-owned model state and tallies.
  int          n_checks = 0;
  int          n_pass = 0;
  int          preload_seen = 0;
  logic        m_div_on = 1'b0;
  int          m_age = 0;
  logic [31:0] m_cnt = 32'd0;

  // Packed order: {pc_we, if_id_we, id_ex_we, ex_mem_we, if_id_fl, id_ex_fl, ex_mem_fl, mem_wb_fl, div_busy}
  localparam logic [8:0] V_IDLE = 9'b1111_0000_0;
  localparam logic [8:0] V_RST  = 9'b0000_1111_0;
  localparam logic [8:0] V_LU   = 9'b0011_0100_0;
  localparam logic [8:0] V_BR   = 9'b1111_1100_0;
  localparam logic [8:0] V_IMEM = 9'b0111_1000_0;
  localparam logic [8:0] V_DIVE = 9'b0001_0010_0;
  localparam logic [8:0] V_DIVW = 9'b0001_0010_1;
  localparam logic [8:0] V_DIVX = 9'b1111_0000_1;
  localparam logic [8:0] V_DMDV = 9'b0000_0001_1;
  localparam logic [8:0] V_DMEM = 9'b0000_0001_0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s at %0t: actual=%h required=%h", nm, $time, act, exp);
    end
  endtask

  function automatic logic [7:0] rule_ctrl(input logic dm, input logic dv, input logic br,
                                           input logic lu, input logic im);
    if (dm)      return 8'b0000_0001;
    else if (dv) return 8'b0001_0010;
    else if (br) return 8'b1111_1100;
    else if (lu) return 8'b0011_0100;
    else if (im) return 8'b0111_1000;
    else         return 8'b1111_0000;
  endfunction

  // Cycle-by-cycle check against the model, then advance the model across the coming rising edge.
  always @(negedge core_clk) begin
    logic [8:0]  act;
    logic [8:0]  exp;
    logic [31:0] exp_cnt;
    logic        dv;
    if (preload_seq != preload_seen) begin
      m_cnt        = 32'hFFFF_FFFE;
      preload_seen = preload_seq;
    end
    if (started) begin
      act = {pc_write_en, if_id_write_en, id_ex_write_en, ex_mem_write_en,
             if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, div_busy};
      dv  = m_div_on ? (m_age < DIV_CYCLES - 1) : div_valid_ex;
      if (rst) begin
        exp     = V_RST;
        exp_cnt = 32'd0;
      end else begin
        exp     = {rule_ctrl(dmem_busy, dv, branch_taken_ex, lu_hazard, imem_busy), m_div_on};
        exp_cnt = m_cnt;
      end
      chk("model_ctrl", 32'(act), 32'(exp));
      chk("model_stall_cycles", stall_cycles, exp_cnt);
      if (lit_vld)     chk("literal_ctrl", 32'(act), 32'(lit_exp));
      if (lit_cnt_vld) chk("literal_stall_cycles", stall_cycles, lit_cnt);
      if (rst) begin
        m_div_on = 1'b0;
        m_age    = 0;
        m_cnt    = 32'd0;
      end else begin
        if (!exp[8]) m_cnt = m_cnt + 32'd1;
        if (m_div_on) begin
          if (m_age >= DIV_CYCLES - 1 && !dmem_busy) m_div_on = 1'b0;
          else m_age = m_age + 1;
        end else if (div_valid_ex) begin
          m_div_on = 1'b1;
          m_age    = 1;
        end
      end
    end
  end

  // inputs: {lu, br, div, imem, dmem}
  task automatic step(input logic r, input logic [4:0] v, input logic lv, input logic [8:0] le,
                      input logic lcv, input logic [31:0] lc);
    @(posedge core_clk);
    #1;
    rst = r;
    {lu_hazard, branch_taken_ex, div_valid_ex, imem_busy, dmem_busy} = v;
    lit_vld     = lv;
    lit_exp     = le;
    lit_cnt_vld = lcv;
    lit_cnt     = lc;
    started     = 1'b1;
  endtask

  initial begin
    // Reset held three cycles with every input high.
    for (int i = 0; i < 3; i++) step(1'b1, 5'b11111, 1'b1, V_RST, 1'b1, 32'd0);
    step(1'b0, 5'b00000, 1'b1, V_IDLE, 1'b1, 32'd0);
    // Load-use: one bubble.
    step(1'b0, 5'b10000, 1'b1, V_LU, 1'b1, 32'd0);
    step(1'b0, 5'b00000, 1'b1, V_IDLE, 1'b1, 32'd1);
    // Isolated divide: three stall cycles, busy for three cycles.
    step(1'b0, 5'b00100, 1'b1, V_DIVE, 1'b1, 32'd1);
    step(1'b0, 5'b00100, 1'b1, V_DIVW, 1'b1, 32'd2);
    step(1'b0, 5'b00100, 1'b1, V_DIVW, 1'b1, 32'd3);
    step(1'b0, 5'b00100, 1'b1, V_DIVX, 1'b1, 32'd4);
    step(1'b0, 5'b00000, 1'b1, V_IDLE, 1'b1, 32'd4);
    // Divide with MEM busy for five cycles from the second divide cycle.
    step(1'b0, 5'b00100, 1'b1, V_DIVE, 1'b1, 32'd4);
    for (int i = 0; i < 5; i++) step(1'b0, 5'b00101, 1'b1, V_DMDV, 1'b1, 32'(5 + i));
    step(1'b0, 5'b00100, 1'b1, V_DIVX, 1'b1, 32'd10);
    step(1'b0, 5'b00000, 1'b1, V_IDLE, 1'b1, 32'd10);
    // Back-to-back divides: re-entry from RUN right after release.
    for (int i = 0; i < 4; i++) step(1'b0, 5'b00100, 1'b0, V_IDLE, 1'b0, 32'd0);
    step(1'b0, 5'b00100, 1'b1, V_DIVE, 1'b1, 32'd13);
    for (int i = 0; i < 3; i++) step(1'b0, 5'b00100, 1'b0, V_IDLE, 1'b0, 32'd0);
    step(1'b0, 5'b00000, 1'b1, V_IDLE, 1'b1, 32'd16);
    // Priority: branch beats load-use and fetch stall, then load-use, then fetch.
    step(1'b0, 5'b11010, 1'b1, V_BR, 1'b0, 32'd0);
    step(1'b0, 5'b10010, 1'b1, V_LU, 1'b0, 32'd0);
    step(1'b0, 5'b00010, 1'b1, V_IMEM, 1'b0, 32'd0);
    // Branch held under MEM busy applies once MEM releases.
    step(1'b0, 5'b01001, 1'b1, V_DMEM, 1'b0, 32'd0);
    step(1'b0, 5'b01000, 1'b1, V_BR, 1'b0, 32'd0);
    // Reset in the middle of a divide aborts it.
    step(1'b0, 5'b00100, 1'b0, V_IDLE, 1'b0, 32'd0);
    step(1'b0, 5'b00100, 1'b1, V_DIVW, 1'b0, 32'd0);
    step(1'b1, 5'b00100, 1'b1, V_RST, 1'b1, 32'd0);
    step(1'b0, 5'b00000, 1'b1, V_IDLE, 1'b1, 32'd0);
    // Counter wrap from a forced preload.
    step(1'b0, 5'b00000, 1'b0, V_IDLE, 1'b0, 32'd0);
    @(posedge core_clk);
    #2;
    force dut.stall_cycles = 32'hFFFF_FFFE;
    preload_seq = preload_seq + 1;
    #1;
    release dut.stall_cycles;
    step(1'b0, 5'b10000, 1'b1, V_LU, 1'b1, 32'hFFFF_FFFE);
    step(1'b0, 5'b10000, 1'b1, V_LU, 1'b1, 32'hFFFF_FFFF);
    step(1'b0, 5'b00000, 1'b1, V_IDLE, 1'b1, 32'd0);
    step(1'b0, 5'b00000, 1'b0, V_IDLE, 1'b0, 32'd0);
    @(posedge core_clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
